bcd_digit_counter: RTL and testbench



---
 rtl/bcd_digit_counter.sv | 93 +++++++++
 tb/tb_bcd_digit_counter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - synchronous mod-N up/down digit counter with 7-segment decode
// Optional macro LAP_HOLD_EN adds a lap-hold display freeze driven by LAP strobes.
module bcd_digit_counter #(
  parameter int MODULUS   = 10,
  parameter int RESET_VAL = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic       UP,
  input  logic       CLR,
  input  logic       LOAD,
  input  logic [3:0] LD_VAL,
  input  logic       LAP,
  output logic [3:0] VALUE,
  output logic       CO,
  output logic [6:0] SEG
);

  if (MODULUS < 2 || MODULUS > 10) begin : g_bad_modulus
    $error("bcd_digit_counter: MODULUS must be in 2..10");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("bcd_digit_counter: RESET_VAL must be below MODULUS");
  end

  localparam logic [3:0] MAX_VAL = 4'(MODULUS - 1);
  localparam logic [3:0] RST_VAL = 4'(RESET_VAL);

  logic [3:0] value_next;
  logic [3:0] seg_src;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  // RST is handled in the register; this is the value for every non-reset edge.
  always_comb begin
    value_next = VALUE;
    if (CLR) begin
      value_next = 4'd0;
    end else if (LOAD) begin
      value_next = (LD_VAL > MAX_VAL) ? MAX_VAL : LD_VAL;
    end else if (CE) begin
      if (UP) value_next = (VALUE == MAX_VAL) ? 4'd0 : VALUE + 4'd1;
      else    value_next = (VALUE == 4'd0) ? MAX_VAL : VALUE - 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) VALUE <= RST_VAL;
    else     VALUE <= value_next;
  end

  // Combinational so the next digit steps on the same edge as this wrap.
  assign CO = CE & ~RST & ~CLR & ~LOAD & (UP ? (VALUE == MAX_VAL) : (VALUE == 4'd0));

`ifdef LAP_HOLD_EN
  logic       hold;
  logic [3:0] disp;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold <= 1'b0;
      disp <= RST_VAL;
    end else if (LAP) begin
      hold <= ~hold;
      if (!hold) disp <= value_next;
    end
  end

  assign seg_src = hold ? disp : VALUE;
`else
  logic unused_lap;
  assign unused_lap = LAP;
  assign seg_src    = VALUE;
`endif

  assign SEG = decode(seg_src);

endmodule

// File: tb/tb_bcd_digit_counter.sv
// tb/tb_bcd_digit_counter.sv - directed-vector bench for bcd_digit_counter
// Define LAP_HOLD_EN for both files to exercise the lap-hold display freeze.
module tb_bcd_digit_counter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // mod-10 digit
  logic a_rst, a_ce, a_up, a_clr, a_load, a_lap;
  logic [3:0] a_ld, a_val;
  logic a_co;
  logic [6:0] a_seg;
  // mod-6 digit
  logic b_rst, b_ce, b_up, b_clr, b_load;
  logic [3:0] b_ld, b_val;
  logic b_co;
  logic [6:0] b_seg;
  // cascade units (mod 10) -> tens (mod 6)
  logic c_rst, c_ce;
  logic [3:0] u_val, t_val;
  logic u_co, t_co;
  logic [6:0] u_seg, t_seg;
  logic zero1 = 1'b0;
  logic [3:0] zero4 = 4'd0;
  logic one1 = 1'b1;

  bcd_digit_counter #(.MODULUS(10), .RESET_VAL(0)) u_a (
    .CLK(CLK), .RST(a_rst), .CE(a_ce), .UP(a_up), .CLR(a_clr), .LOAD(a_load),
    .LD_VAL(a_ld), .LAP(a_lap), .VALUE(a_val), .CO(a_co), .SEG(a_seg));

  bcd_digit_counter #(.MODULUS(6), .RESET_VAL(0)) u_b (
    .CLK(CLK), .RST(b_rst), .CE(b_ce), .UP(b_up), .CLR(b_clr), .LOAD(b_load),
    .LD_VAL(b_ld), .LAP(zero1), .VALUE(b_val), .CO(b_co), .SEG(b_seg));

  bcd_digit_counter #(.MODULUS(10), .RESET_VAL(0)) u_units (
    .CLK(CLK), .RST(c_rst), .CE(c_ce), .UP(one1), .CLR(zero1), .LOAD(zero1),
    .LD_VAL(zero4), .LAP(zero1), .VALUE(u_val), .CO(u_co), .SEG(u_seg));

  bcd_digit_counter #(.MODULUS(6), .RESET_VAL(0)) u_tens (
    .CLK(CLK), .RST(c_rst), .CE(u_co), .UP(one1), .CLR(zero1), .LOAD(zero1),
    .LD_VAL(zero4), .LAP(zero1), .VALUE(t_val), .CO(t_co), .SEG(t_seg));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  default: return 7'h00;
    endcase
  endfunction

  task automatic tick();
    @(negedge CLK);
  endtask

  int tens_pulses;

  initial begin
    {a_rst, a_ce, a_up, a_clr, a_load, a_lap} = 6'b100000; a_ld = 4'd0;
    {b_rst, b_ce, b_up, b_clr, b_load} = 5'b10000; b_ld = 4'd0;
    c_rst = 1'b1; c_ce = 1'b0;
    @(negedge CLK);
    tick();
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    #1;
    check("rst_value", a_val, 0);
    check("rst_co", a_co, 0);
    check("rst_seg", a_seg, 7'h3F);

    // up wrap over 12 cycles
    a_ce = 1'b1; a_up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      #1 check($sformatf("up_co_%0d", i), a_co, ((i - 1) % 10 == 9) ? 1 : 0);
      tick();
      #1 check($sformatf("up_val_%0d", i), a_val, i % 10);
      check($sformatf("up_seg_%0d", i), a_seg, seg_of(i % 10));
    end
    check("seg_nine", seg_of(9), 7'h6F);
    for (int i = 0; i < 5; i++) tick();
    #1 check("pre_rst_val", a_val, 7);
    a_rst = 1'b1;
    #1 check("co_in_rst", a_co, 0);
    tick();
    a_rst = 1'b0;
    #1 check("rst_mid_count", a_val, 0);

    // priority and load clamp
    a_ce = 1'b0; a_load = 1'b1; a_ld = 4'd12;
    tick();
    #1 check("load_clamp", a_val, 9);
    a_ce = 1'b1; a_ld = 4'd3;
    #1 check("co_in_load", a_co, 0);
    tick();
    #1 check("load_over_ce", a_val, 3);
    a_clr = 1'b1; a_ld = 4'd5;
    #1 check("co_in_clr", a_co, 0);
    tick();
    #1 check("clr_over_load", a_val, 0);
    a_clr = 1'b0; a_ce = 1'b0; a_ld = 4'd9;
    tick();
    a_load = 1'b0; a_ce = 1'b1;
    #1 check("co_at_nine", a_co, 1);
    tick();
    a_ce = 1'b0;
    #1 check("wrap_after_load", a_val, 0);
    tick();
    #1 check("hold_no_ce", a_val, 0);
    check("co_no_ce", a_co, 0);

    // mod-6 down wrap
    b_load = 1'b1; b_ld = 4'd7;
    tick();
    #1 check("m6_clamp", b_val, 5);
    b_ld = 4'd1;
    tick();
    b_load = 1'b0; b_ce = 1'b1; b_up = 1'b0;
    #1 check("m6_co_at1", b_co, 0);
    tick();
    #1 check("m6_dn0", b_val, 0);
    check("m6_co_at0", b_co, 1);
    tick();
    #1 check("m6_dn5", b_val, 5);
    check("m6_seg5", b_seg, 7'h6D);
    check("m6_co_at5", b_co, 0);
    tick();
    #1 check("m6_dn4", b_val, 4);
    b_up = 1'b1;
    tick();
    #1 check("m6_dir_change", b_val, 5);
    check("m6_co_up5", b_co, 1);
    b_ce = 1'b0;

    // cascade 60 steps
    c_ce = 1'b1;
    tens_pulses = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (t_co) begin
        tens_pulses++;
        check("tens_co_units", u_val, 9);
        check("tens_co_tens", t_val, 5);
      end
      tick();
      #1 check($sformatf("cas_u_%0d", i), u_val, (i + 1) % 10);
      check($sformatf("cas_t_%0d", i), t_val, ((i + 1) / 10) % 6);
    end
    check("tens_co_count", tens_pulses, 1);
    c_ce = 1'b0;

    // lap strobe
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0; a_load = 1'b1; a_ld = 4'd3;
    tick();
    a_load = 1'b0; a_ce = 1'b1; a_up = 1'b1; a_lap = 1'b1;
    tick();
    a_lap = 1'b0;
    #1 check("lap_val4", a_val, 4);
    check("lap_seg4", a_seg, 7'h66);
    for (int i = 0; i < 3; i++) tick();
    #1 check("lap_val7", a_val, 7);
`ifdef LAP_HOLD_EN
    check("lap_frozen", a_seg, 7'h66);
    a_lap = 1'b1;
    tick();
    a_lap = 1'b0;
    #1 check("lap_release_val", a_val, 8);
    check("lap_release_seg", a_seg, 7'h7F);
    a_lap = 1'b1;
    tick();
    a_lap = 1'b0;
    tick();
    #1 check("lap2_val", a_val, 0);
    check("lap2_seg", a_seg, 7'h6F);
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    tick();
    #1 check("lap_rst_val", a_val, 1);
    check("lap_rst_seg", a_seg, 7'h06);
`else
    check("lap_ignored", a_seg, 7'h07);
`endif
    a_ce = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
